// File: rtl/boe_pkg.sv
// Shared types and constants for the BOE scheduler: FSM states, bus widths
// and default limits, plus the packet-length legality helper.
package boe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_SEND    = 2'd2,
    ST_COLLECT = 2'd3
  } state_e;

  localparam int DATA_W      = 8;
  localparam int RES_W       = 11;
  localparam int LEN_W       = 3;
  localparam int RCNT_W      = 4;
  localparam int DEF_MAX_LEN = 6;
  localparam int DEF_TIMEOUT = 16;

  // A length is usable only when it is non-zero and fits the engine.
  function automatic logic len_legal(input logic [LEN_W-1:0] len, input int max_len);
    return (len != 3'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/boe_sched_rr_arb2.sv
// Two-way round-robin pick: a sole requester always wins, a tie goes to ptr.
// Purely combinational; legality is reported for the winner only.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] legal,
  input  logic       ptr,
  output logic       win_valid,
  output logic       win_id,
  output logic       win_legal
);

  // winner selection
  always_comb begin
    win_valid = |req;
    if (req[0] && req[1]) begin
      win_id = ptr;
    end else if (req[1]) begin
      win_id = 1'b1;
    end else begin
      win_id = 1'b0;
    end
    win_legal = legal[win_id];
  end

endmodule

// File: rtl/boe_sched.sv
// Schedules two requesters onto one statistics engine: grant, forward the
// packet bytes, then route the engine's len+2 results back to the owner.
module boe_sched
  import boe_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  input  logic              dv0,
  input  logic              dv1,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rej0,
  output logic              rej1,
  output logic              eng_start,
  output logic [LEN_W-1:0]  eng_num,
  output logic              eng_dv,
  output logic [DATA_W-1:0] eng_data,
  input  logic              eng_rvalid,
  input  logic [RES_W-1:0]  eng_result,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic              rsp_last,
  output logic [RES_W-1:0]  rsp_data,
  output logic              busy,
  output logic              tout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d, owner_q, owner_d;
  logic [LEN_W-1:0]    len_q, len_d, beat_q, beat_d;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [1:0]          gnt_q, gnt_d, rej_q, rej_d;
  logic                eng_start_q, eng_start_d, eng_dv_q, eng_dv_d;
  logic [DATA_W-1:0]   eng_data_q, eng_data_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_last_q, rsp_last_d;
  logic [RES_W-1:0]    rsp_data_q, rsp_data_d;
  logic                busy_q, busy_d, tout_q, tout_d;

  logic                win_valid_s, win_id_s, win_legal_s, expire_s, sel_dv_s;
  logic [1:0]          legal_s;
  logic [LEN_W-1:0]    win_len_s;
  logic [DATA_W-1:0]   sel_din_s;

  assign legal_s   = {len_legal(len1, MAX_LEN), len_legal(len0, MAX_LEN)};
  assign win_len_s = win_id_s ? len1 : len0;
  assign sel_dv_s  = owner_q ? dv1 : dv0;
  assign sel_din_s = owner_q ? din1 : din0;

  rr_arb2 u_arb (
    .req       ({req1, req0}),
    .legal     (legal_s),
    .ptr       (ptr_q),
    .win_valid (win_valid_s),
    .win_id    (win_id_s),
    .win_legal (win_legal_s)
  );

  // next-state, counters and next output values
  always_comb begin
    state_d = state_q;  ptr_d = ptr_q;    owner_d = owner_q;
    len_d   = len_q;    beat_d = beat_q;  rcnt_d = rcnt_q;  wd_d = wd_q;
    gnt_d = 2'b00;  rej_d = 2'b00;  eng_start_d = 1'b0;
    eng_dv_d = 1'b0;  eng_data_d = '0;
    rsp_valid_d = 1'b0;  rsp_id_d = 1'b0;  rsp_last_d = 1'b0;  rsp_data_d = '0;
    tout_d = 1'b0;  expire_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (win_valid_s && win_legal_s) begin
          owner_d          = win_id_s;
          len_d            = win_len_s;
          gnt_d[win_id_s]  = 1'b1;
          eng_start_d      = 1'b1;
          state_d          = ST_GRANT;
        end else if (win_valid_s) begin
          rej_d[win_id_s]  = 1'b1;
        end else begin
          state_d          = ST_IDLE;
        end
      end
      ST_GRANT: begin
        state_d = ST_SEND;
        beat_d  = '0;
        wd_d    = '0;
      end
      ST_SEND: begin
        eng_dv_d   = sel_dv_s;
        eng_data_d = sel_dv_s ? sel_din_s : '0;
        if (sel_dv_s && (beat_q == len_q - 3'd1)) begin
          state_d = ST_COLLECT;
          beat_d  = '0;
          rcnt_d  = '0;
          wd_d    = '0;
        end else begin
          beat_d   = beat_q + {2'd0, sel_dv_s};
          expire_s = !eng_rvalid && (wd_q == WD_LAST);
          wd_d     = eng_rvalid ? '0 : wd_q + WD_W'(1);
        end
      end
      ST_COLLECT: begin
        if (eng_rvalid) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = owner_q;
          rsp_data_d  = eng_result;
          wd_d        = '0;
          // the (len+2)-th result closes the packet
          if (rcnt_q == {1'b0, len_q} + 4'd1) begin
            rsp_last_d = 1'b1;
            state_d    = ST_IDLE;
            ptr_d      = ~ptr_q;
            rcnt_d     = '0;
            len_d      = '0;
          end else begin
            rcnt_d     = rcnt_q + 4'd1;
          end
        end else begin
          expire_s = (wd_q == WD_LAST);
          wd_d     = wd_q + WD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (expire_s) begin
      tout_d  = 1'b1;
      state_d = ST_IDLE;
      ptr_d   = ~ptr_q;
      beat_d  = '0;
      rcnt_d  = '0;
      wd_d    = '0;
      len_d   = '0;
    end else begin
      tout_d  = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;  ptr_q <= 1'b0;  owner_q <= 1'b0;
      len_q <= '0;  beat_q <= '0;  rcnt_q <= '0;  wd_q <= '0;
      gnt_q <= 2'b00;  rej_q <= 2'b00;  eng_start_q <= 1'b0;
      eng_dv_q <= 1'b0;  eng_data_q <= '0;
      rsp_valid_q <= 1'b0;  rsp_id_q <= 1'b0;  rsp_last_q <= 1'b0;  rsp_data_q <= '0;
      busy_q <= 1'b0;  tout_q <= 1'b0;
    end else begin
      state_q <= state_d;  ptr_q <= ptr_d;  owner_q <= owner_d;
      len_q <= len_d;  beat_q <= beat_d;  rcnt_q <= rcnt_d;  wd_q <= wd_d;
      gnt_q <= gnt_d;  rej_q <= rej_d;  eng_start_q <= eng_start_d;
      eng_dv_q <= eng_dv_d;  eng_data_q <= eng_data_d;
      rsp_valid_q <= rsp_valid_d;  rsp_id_q <= rsp_id_d;
      rsp_last_q <= rsp_last_d;  rsp_data_q <= rsp_data_d;
      busy_q <= busy_d;  tout_q <= tout_d;
    end
  end

  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign rej0      = rej_q[0];
  assign rej1      = rej_q[1];
  assign eng_start = eng_start_q;
  assign eng_num   = len_q;
  assign eng_dv    = eng_dv_q;
  assign eng_data  = eng_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign tout      = tout_q;

endmodule

// File: tb/tb_boe_sched.sv
// Directed bench for boe_sched: one task per scenario, inline expected values.
module tb_boe_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, dv0 = 1'b0, dv1 = 1'b0;
  logic [2:0]  len0 = 3'd0, len1 = 3'd0;
  logic [7:0]  din0 = 8'd0, din1 = 8'd0;
  logic        gnt0, gnt1, rej0, rej1, eng_start, eng_dv;
  logic [2:0]  eng_num;
  logic [7:0]  eng_data;
  logic        eng_rvalid = 1'b0;
  logic [10:0] eng_result = 11'd0;
  logic        rsp_valid, rsp_id, rsp_last, busy, tout;
  logic [10:0] rsp_data;
  logic [32:0] all_out;

  int errs   = 0;
  int checks = 0;

  logic [7:0]  bdat [3];
  logic [10:0] bres [5];

  always #5 clk = ~clk;

  assign all_out = {gnt0, gnt1, rej0, rej1, eng_start, eng_num, eng_dv, eng_data,
                    rsp_valid, rsp_id, rsp_last, rsp_data, busy, tout};

  boe_sched dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .dv0(dv0), .dv1(dv1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .rej0(rej0), .rej1(rej1),
    .eng_start(eng_start), .eng_num(eng_num), .eng_dv(eng_dv), .eng_data(eng_data),
    .eng_rvalid(eng_rvalid), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_last(rsp_last), .rsp_data(rsp_data),
    .busy(busy), .tout(tout)
  );

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs one packet for whoever is granted; reports observations, compares nothing.
  task automatic serve(output int gid, output int nval, output int nlast,
                       output int idbad, output int wcyc);
    int plen;
    gid = -1; nval = 0; nlast = 0; idbad = 0; wcyc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        gid  = gnt1 ? 1 : 0;
        wcyc = c;
        break;
      end
    end
    if (gid < 0) return;
    plen = (gid == 1) ? int'(len1) : int'(len0);
    if (gid == 0) req0 = 1'b0; else req1 = 1'b0;
    @(negedge clk);
    for (int k = 0; k < plen; k++) begin
      if (gid == 0) begin dv0 = 1'b1; din0 = 8'(k + 1); end
      else          begin dv1 = 1'b1; din1 = 8'(k + 1); end
      @(negedge clk);
    end
    dv0 = 1'b0; dv1 = 1'b0;
    for (int k = 0; k < plen + 2; k++) begin
      eng_rvalid = 1'b1;
      eng_result = 11'(100 + k);
      @(negedge clk);
      if (rsp_valid) nval++;
      if (rsp_last) nlast++;
      if (rsp_valid && (int'(rsp_id) != gid)) idbad++;
    end
    eng_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (all_out !== 33'd0) begin errs++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== 33'd0) begin errs++; $display("FAIL idle_outputs: got %h want 0", all_out); end
    eng_rvalid = 1'b1; eng_result = 11'd77;
    @(negedge clk);
    eng_rvalid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL idle_rvalid_drop: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_basic;
    req0 = 1'b1; len0 = 3'd3;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, eng_start, busy} !== 4'b1011 || eng_num !== 3'd3) begin
      errs++; $display("FAIL basic_grant: gnt0/gnt1/start/busy=%b num=%0d want 1011 3",
                       {gnt0, gnt1, eng_start, busy}, eng_num);
    end
    req0 = 1'b0; dv1 = 1'b1; din1 = 8'hEE;
    @(negedge clk);
    checks++;
    if ({gnt0, eng_start, busy} !== 3'b001) begin
      errs++; $display("FAIL basic_grant_pulse: gnt0/start/busy=%b want 001", {gnt0, eng_start, busy});
    end
    for (int k = 0; k < 3; k++) begin
      dv0 = 1'b1; din0 = bdat[k];
      @(negedge clk);
      checks++;
      if (eng_dv !== 1'b1 || eng_data !== bdat[k]) begin
        errs++; $display("FAIL basic_beat%0d: dv=%b data=%0d want 1 %0d", k, eng_dv, eng_data, bdat[k]);
      end
    end
    dv0 = 1'b0; dv1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      eng_rvalid = 1'b1; eng_result = bres[k];
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== bres[k] ||
          rsp_last !== (k == 4) || eng_dv !== 1'b0 || (k < 4 && eng_num !== 3'd3)) begin
        errs++; $display("FAIL basic_result%0d: v=%b id=%b data=%0d last=%b num=%0d want 1 0 %0d %b 3",
                         k, rsp_valid, rsp_id, rsp_data, rsp_last, eng_num, bres[k], (k == 4));
      end
    end
    eng_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_last, busy} !== 3'b000) begin
      errs++; $display("FAIL basic_done: valid/last/busy=%b want 000", {rsp_valid, rsp_last, busy});
    end
  endtask

  task automatic test_both;
    int g, n, l, bad, w;
    do_reset();
    req0 = 1'b1; len0 = 3'd2; req1 = 1'b1; len1 = 3'd2;
    serve(g, n, l, bad, w);
    checks++;
    if (g != 0 || n != 4 || l != 1 || bad != 0) begin
      errs++; $display("FAIL both_first: gid=%0d nval=%0d nlast=%0d idbad=%0d want 0 4 1 0", g, n, l, bad);
    end
    serve(g, n, l, bad, w);
    checks++;
    if (g != 1 || w != 0 || n != 4 || l != 1 || bad != 0) begin
      errs++; $display("FAIL both_second: gid=%0d wait=%0d nval=%0d nlast=%0d idbad=%0d want 1 0 4 1 0",
                       g, w, n, l, bad);
    end
  endtask

  task automatic test_reject;
    int g, n, l, bad, w;
    do_reset();
    req1 = 1'b1; len1 = 3'd7;
    @(negedge clk);
    checks++;
    if ({rej1, rej0, gnt1, eng_start, busy} !== 5'b10000) begin
      errs++; $display("FAIL reject_len7: rej1/rej0/gnt1/start/busy=%b want 10000",
                       {rej1, rej0, gnt1, eng_start, busy});
    end
    req1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({rej1, gnt1, busy} !== 3'b000) begin
      errs++; $display("FAIL reject_pulse: rej1/gnt1/busy=%b want 000", {rej1, gnt1, busy});
    end
    req0 = 1'b1; len0 = 3'd0;
    @(negedge clk);
    checks++;
    if ({rej0, gnt0, busy} !== 3'b100) begin
      errs++; $display("FAIL reject_len0: rej0/gnt0/busy=%b want 100", {rej0, gnt0, busy});
    end
    req0 = 1'b0;
    @(negedge clk);
    req0 = 1'b1; len0 = 3'd1; req1 = 1'b1; len1 = 3'd6;
    serve(g, n, l, bad, w);
    checks++;
    if (g != 0 || n != 3 || l != 1) begin
      errs++; $display("FAIL reject_ptr_kept: gid=%0d nval=%0d nlast=%0d want 0 3 1", g, n, l);
    end
    serve(g, n, l, bad, w);
    checks++;
    if (g != 1 || n != 8 || l != 1 || bad != 0) begin
      errs++; $display("FAIL maxlen_packet: gid=%0d nval=%0d nlast=%0d idbad=%0d want 1 8 1 0", g, n, l, bad);
    end
  endtask

  task automatic test_timeout;
    int g, n, l, bad, w, tcyc;
    bit got, saw;
    got = 1'b0; saw = 1'b0; tcyc = 0;
    req0 = 1'b1; len0 = 3'd4;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt0) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin errs++; $display("FAIL tout_grant: gnt0 never seen, want 1"); end
    req0 = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      dv0 = 1'b1; din0 = 8'(10 + k);
      @(negedge clk);
    end
    dv0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      eng_rvalid = 1'b1; eng_result = 11'(500 + k);
      @(negedge clk);
    end
    eng_rvalid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rsp_valid || rsp_last) saw = 1'b1;
      if (tout) begin tcyc = c; break; end
    end
    checks++;
    if (tcyc != 16) begin errs++; $display("FAIL tout_cycles: got %0d want 16", tcyc); end
    checks++;
    if (saw || busy !== 1'b0) begin
      errs++; $display("FAIL tout_abort: rsp_seen=%b busy=%b want 0 0", saw, busy);
    end
    @(negedge clk);
    checks++;
    if (tout !== 1'b0) begin errs++; $display("FAIL tout_pulse: got %b want 0", tout); end
    req1 = 1'b1; len1 = 3'd1;
    serve(g, n, l, bad, w);
    checks++;
    if (g != 1 || n != 3 || l != 1) begin
      errs++; $display("FAIL tout_recover: gid=%0d nval=%0d nlast=%0d want 1 3 1", g, n, l);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    bit got;
    got = 1'b0; bad = 0;
    req0 = 1'b1; len0 = 3'd6;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt0) begin got = 1'b1; break; end
    end
    req0 = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      dv0 = 1'b1; din0 = 8'(k + 40);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!got || all_out !== 33'd0) begin
      errs++; $display("FAIL reset_mid: granted=%b outputs=%h want 1 0", got, all_out);
    end
    dv0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      eng_rvalid = c[0];
      eng_result = 11'(c);
      @(negedge clk);
      if (rsp_valid || rsp_last || busy) bad++;
    end
    eng_rvalid = 1'b0;
    checks++;
    if (bad != 0) begin errs++; $display("FAIL reset_release: bad cycles=%0d want 0", bad); end
  endtask

  task automatic test_alternate;
    int g, n, l, bad, w, prev, n0, n1;
    prev = -1; n0 = 0; n1 = 0;
    req0 = 1'b1; len0 = 3'd2; req1 = 1'b1; len1 = 3'd3;
    for (int i = 0; i < 10; i++) begin
      serve(g, n, l, bad, w);
      checks++;
      if (g < 0 || g == prev || l != 1 || bad != 0) begin
        errs++; $display("FAIL alternate_pkt%0d: gid=%0d prev=%0d nlast=%0d idbad=%0d want other 1 0",
                         i, g, prev, l, bad);
      end
      if (g == 0) begin n0++; req0 = 1'b1; end
      else if (g == 1) begin n1++; req1 = 1'b1; end
      else begin n0 = n0; end
      prev = g;
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (n0 != 5 || n1 != 5) begin
      errs++; $display("FAIL alternate_fair: n0=%0d n1=%0d want 5 5", n0, n1);
    end
  endtask

  initial begin
    bdat[0] = 8'd5;  bdat[1] = 8'd9;   bdat[2] = 8'd2;
    bres[0] = 11'd9; bres[1] = 11'd16; bres[2] = 11'd2; bres[3] = 11'd5; bres[4] = 11'd9;
    test_reset();
    test_basic();
    test_both();
    test_reject();
    test_timeout();
    test_reset_mid();
    test_alternate();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, want finished");
    $fatal(1);
  end

endmodule
